// File: rtl/half_adder_led.sv
// Switch-driven half-adder demonstrator: two switches are synchronised and debounced.
// The operands, carry and sum are driven onto a registered 16-bit LED bank.
module half_adder_led #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          LED_ACTIVE_LOW  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stswi,
    output logic [15:0] stled
);

    localparam int unsigned      CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]      LED_POLARITY = LED_ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            sw_q;
    logic [1:0]            sw_d;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;
    logic [15:0]           led_q;
    logic [15:0]           led_d;
    logic                  sum;
    logic                  carry;

    // Each bit keeps its own count of consecutive disagreeing clocks.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sw_d[i]  = sw_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != sw_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        sum   = sw_q[0] ^ sw_q[1];
        carry = sw_q[0] & sw_q[1];
        led_d = {6'b0, sum, carry, 6'b0, sw_q[1], sw_q[0]} ^ LED_POLARITY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sw_q    <= '0;
            cnt_q   <= '0;
            led_q   <= LED_POLARITY;
        end else begin
            sync1_q <= stswi;
            sync2_q <= sync1_q;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign stled = led_q;

endmodule

// File: tb/tb_half_adder_led.sv
// Scoreboard bench for half_adder_led: an active-high and an active-low instance run side by side.
module tb_half_adder_led;

    typedef struct {
        int          due;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  stswi;
    logic [15:0] stled_hi;
    logic [15:0] stled_lo;

    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    half_adder_led #(.DEBOUNCE_CYCLES(4), .LED_ACTIVE_LOW(1'b0)) dut_hi (
        .clk   (clk),
        .rst   (rst),
        .stswi (stswi),
        .stled (stled_hi)
    );

    half_adder_led #(.DEBOUNCE_CYCLES(4), .LED_ACTIVE_LOW(1'b1)) dut_lo (
        .clk   (clk),
        .rst   (rst),
        .stswi (stswi),
        .stled (stled_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Reset held for 5 edges, then 20 idle edges with switches off.
    task automatic test_reset();
        int   base;
        exp_t e;
        rst   = 1'b1;
        stswi = 2'b00;
        base  = cyc;
        for (int i = 1; i <= 25; i++) q.push_back('{base + i, 16'h0000, "reset"});
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 5) rst = 1'b0;
            while (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks += 2;
                if (e.due != cyc || stled_hi !== e.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_hi, e.exp);
                end
                if (e.due != cyc || stled_lo !== ~e.exp) begin
                    errors++;
                    $display("FAIL %s_low cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_lo, ~e.exp);
                end
            end
        end
    endtask

    // New switch level held: old value for 6 edges, new value from the 7th edge on.
    task automatic test_level(input logic [1:0] sw, input logic [15:0] old_v,
                              input logic [15:0] new_v, input string tag);
        int   base;
        exp_t e;
        stswi = sw;
        base  = cyc;
        for (int i = 1; i <= 20; i++) q.push_back('{base + i, (i >= 7) ? new_v : old_v, tag});
        repeat (20) begin
            @(negedge clk);
            while (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks += 2;
                if (e.due != cyc || stled_hi !== e.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_hi, e.exp);
                end
                if (e.due != cyc || stled_lo !== ~e.exp) begin
                    errors++;
                    $display("FAIL %s_low cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_lo, ~e.exp);
                end
            end
        end
    endtask

    // A pulse on A of len clocks; a 4-clock pulse is just long enough to be accepted
    // and shows on edges 7..10, anything shorter never reaches the LEDs.
    task automatic test_pulse(input int len, input string tag);
        int   base;
        exp_t e;
        stswi = 2'b01;
        base  = cyc;
        for (int i = 1; i <= 20; i++)
            q.push_back('{base + i, (len >= 4 && i >= 7 && i <= 10) ? 16'h0201 : 16'h0000, tag});
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == len) stswi = 2'b00;
            while (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks += 2;
                if (e.due != cyc || stled_hi !== e.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_hi, e.exp);
                end
                if (e.due != cyc || stled_lo !== ~e.exp) begin
                    errors++;
                    $display("FAIL %s_low cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_lo, ~e.exp);
                end
            end
        end
    endtask

    // One-clock reset with both switches on: cleared on the reset edge, back 7 edges later.
    task automatic test_reset_mid();
        int   base;
        exp_t e;
        rst  = 1'b1;
        base = cyc;
        for (int i = 1; i <= 20; i++) q.push_back('{base + i, (i >= 8) ? 16'h0103 : 16'h0000, "reset_mid"});
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            while (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks += 2;
                if (e.due != cyc || stled_hi !== e.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_hi, e.exp);
                end
                if (e.due != cyc || stled_lo !== ~e.exp) begin
                    errors++;
                    $display("FAIL %s_low cyc=%0d stled=%h expected=%h", e.tag, cyc, stled_lo, ~e.exp);
                end
            end
        end
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stswi  = 2'b00;
        @(negedge clk);

        test_reset();
        test_level(2'b01, 16'h0000, 16'h0201, "a_only");
        test_level(2'b10, 16'h0201, 16'h0202, "b_only");
        test_level(2'b11, 16'h0202, 16'h0103, "both");
        test_level(2'b00, 16'h0103, 16'h0000, "both_off");
        test_pulse(3, "glitch");
        test_pulse(4, "min_pulse");
        test_level(2'b11, 16'h0000, 16'h0103, "both_again");
        test_reset_mid();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
